seven_seg_scanner: RTL
======================

# seven_seg_scanner

Time-multiplexed controller for a 4-digit, common-anode 7-segment display. Holds a shadow copy of a 16-bit hex value, scans the digits one at a time with a blanking gap between digits to suppress ghosting, and decodes each nibble to segment patterns. Display updates arrive over a valid/ready handshake and are committed only at frame boundaries, so a frame never mixes old and new digits. Sits between the system-level display registers and the board's anode/segment pins.

## Interface
- DIV, 100000, drive cycles per digit; ≥1 (1 ms at 100 MHz).
- BLANK, 1000, all-off cycles before each digit; 0 disables the gap.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  update request.
- upd_ready  out  1  block can accept an update.
- upd_value  in  16  four hex digits; [3:0] is digit 0 (rightmost).
- upd_en  in  4  per-digit enable; 0 keeps that anode off.
- upd_dp  in  4  per-digit decimal point; 1 lights it.
- an  out  4  anodes, active-low.
- seg  out  7  segments a..g on bits 0..6, active-low.
- dp  out  1  decimal point, active-low.
- frame  out  1  one-cycle pulse at each frame start.

## Operation
- Registers: shadow {value, en, dp}; pending {value, en, dp}; pend_flag; idx[1:0]; cycle counter sized to max(DIV, BLANK); state.
- States: BLANK, DRIVE.
- BLANK: an=4'b1111, seg=7'b1111111, dp=1. Counts BLANK cycles, then goes to DRIVE. If BLANK=0, BLANK is skipped; DRIVE follows DRIVE directly.
- DRIVE: an[idx]=~en[idx], other anodes 1. seg=decode(value[4*idx+:4]). dp=~dp[idx]. Counts DIV cycles, then idx←idx+1 mod 4 and goes to BLANK.
- Decode, active-low: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0111111 (dash), B→0000011, C→1000110, D→0100001, E→0000110, F→0001110.
- Handshake: a transfer occurs when upd_valid && upd_ready are both high on a clock edge. The transfer captures the inputs into pending and sets pend_flag. upd_ready = ~pend_flag. When upd_ready is low, upd_valid is ignored; no capture, no error.
- Frame boundary: the edge on which idx wraps 3→0, or the first edge after reset. On that edge, if pend_flag=1: shadow←pending and pend_flag←0. frame pulses for the first cycle of the new frame.
- A transfer on the same edge as a boundary commit lands in pending and is shown at the next boundary, not the current one.

## Timing
- Reset values: an=4'b1111, seg=7'b1111111, dp=1, upd_ready=1, frame=0, idx=0, state=BLANK, counter=0, shadow value=16'h0000, shadow en=4'b0000, shadow dp=4'b0000, pend_flag=0.
- The first frame starts on the first edge after rst_n deasserts.
- Outputs are registered. They change on the same edge as the state/idx transition; no combinational path exists from inputs to outputs.
- Frame length = 4·(BLANK+DIV) cycles.
- Update latency: from the transfer edge to new digit 0 at the pins is at most one frame + BLANK cycles.
- upd_ready goes low the cycle after a transfer and returns high the cycle after the commit.
- Reset mid-frame: all outputs go to their reset values immediately (asynchronously). Pending data is discarded.

## Configuration
- SEVSEG_LZ_BLANK_EN defined: leading-zero blanking is enabled. In DRIVE, digit idx∈{3,2,1} keeps its anode high when its nibble and every higher nibble are 0. Digit 0 is never suppressed. Timing is unchanged; blanked slots still last DIV cycles.
- Undefined: all enabled digits are shown, including leading zeros.

## Test plan
- Reset, DIV=4, BLANK=2: an=1111, seg=1111111, upd_ready=1; frame pulses at cycle 1 after release, then every 24 cycles.
- Update value=16'h12AF, en=1111, dp=0100: after the commit, each digit is driven for 4 cycles in order 0,1,2,3 with patterns F=0001110, A=0111111, 2=0100100, 1=1111001. dp=0 only while idx=2. Each digit slot is preceded by 2 all-off cycles.
- Back-to-back updates: 16'h0001 accepted and upd_valid held with 16'h0002. upd_ready stays low until the boundary. 16'h0002 is captured the cycle after the commit and is displayed one frame later.
- en=0101, value=16'h8888: an never equals 1101 or 0111 (digits 1 and 3 stay off). Digits 0 and 2 show 0000000.
- With SEVSEG_LZ_BLANK_EN, value=16'h0030, en=1111: only digits 0 ("0", 1000000) and 1 ("3") light, digits 2 and 3 stay dark. Without the macro, all four digits light.
- Assert rst_n low in the middle of a DRIVE slot with an update pending: outputs reach their reset values with no clock edge, and after release the shadow is 0 and the display is dark.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 4-digit common-anode 7-segment scanner with frame-aligned shadow updates.
// Optional leading-zero blanking is compiled in when SEVSEG_LZ_BLANK_EN is defined.
module seven_seg_scanner #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_value,
  input  logic [3:0]  upd_en,
  input  logic [3:0]  upd_dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CMAX  = (DIV > BLANK) ? DIV : BLANK;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;
  // With no gap configured, a finished digit goes straight to the next DRIVE slot.
  localparam logic [0:0] ST_SLOT  = (BLANK > 0) ? ST_BLANK : ST_DRIVE;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0111111;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef SEVSEG_LZ_BLANK_EN
  // hi is value[15:4]; a digit is a leading zero when it and all higher nibbles are 0.
  function automatic logic lz_blank(input logic [11:0] hi, input logic [1:0] i);
    logic b;
    case (i)
      2'd3:    b = (hi[11:8] == 4'h0);
      2'd2:    b = (hi[11:4] == 8'h00);
      2'd1:    b = (hi == 12'h000);
      default: b = 1'b0;
    endcase
    return b;
  endfunction
`endif

  logic [0:0]       state_p0, state_nx;
  logic [CNT_W-1:0] cnt_p0, cnt_nx;
  logic [1:0]       idx_p0, idx_nx;
  logic             started_p0;
  logic             wrap, boundary, commit, xfer;

  logic             pend_flag;
  logic [15:0]      pd_val;
  logic [3:0]       pd_en, pd_dp;
  logic [15:0]      sh_val, sh_val_nx;
  logic [3:0]       sh_en, sh_en_nx, sh_dp, sh_dp_nx;

  logic [3:0]       an_nx, an_p1;
  logic [6:0]       seg_nx, seg_p1;
  logic             dp_nx, dp_p1, frame_p1;

  // Stage p0: scan sequencing and frame boundary detection
  always_comb begin
    state_nx = state_p0;
    cnt_nx   = cnt_p0;
    idx_nx   = idx_p0;
    wrap     = 1'b0;
    if (!started_p0) begin
      state_nx = ST_SLOT;
      cnt_nx   = '0;
      idx_nx   = 2'd0;
    end else if (state_p0 == ST_BLANK) begin
      if (cnt_p0 == BLK_LAST) begin
        state_nx = ST_DRIVE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt_p0 + 1'b1;
      end
    end else begin
      if (cnt_p0 == DIV_LAST) begin
        state_nx = ST_SLOT;
        cnt_nx   = '0;
        idx_nx   = idx_p0 + 2'd1;
        wrap     = (idx_p0 == 2'd3);
      end else begin
        cnt_nx = cnt_p0 + 1'b1;
      end
    end
  end

  assign boundary  = wrap | ~started_p0;
  assign commit    = boundary & pend_flag;
  assign xfer      = upd_valid & ~pend_flag;
  assign upd_ready = ~pend_flag;

  assign sh_val_nx = commit ? pd_val : sh_val;
  assign sh_en_nx  = commit ? pd_en  : sh_en;
  assign sh_dp_nx  = commit ? pd_dp  : sh_dp;

  // Stage p1: pin values for the slot being entered, from the post-commit shadow
  always_comb begin
    an_nx  = 4'b1111;
    seg_nx = 7'b1111111;
    dp_nx  = 1'b1;
    if (state_nx == ST_DRIVE) begin
      seg_nx = seg_decode(sh_val_nx[{idx_nx, 2'b00} +: 4]);
      dp_nx  = ~sh_dp_nx[idx_nx];
`ifdef SEVSEG_LZ_BLANK_EN
      an_nx[idx_nx] = ~(sh_en_nx[idx_nx] & ~lz_blank(sh_val_nx[15:4], idx_nx));
`else
      an_nx[idx_nx] = ~sh_en_nx[idx_nx];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0   <= ST_BLANK;
      cnt_p0     <= '0;
      idx_p0     <= 2'd0;
      started_p0 <= 1'b0;
      pend_flag  <= 1'b0;
      sh_val     <= 16'h0000;
      sh_en      <= 4'b0000;
      sh_dp      <= 4'b0000;
      an_p1      <= 4'b1111;
      seg_p1     <= 7'b1111111;
      dp_p1      <= 1'b1;
      frame_p1   <= 1'b0;
    end else begin
      state_p0   <= state_nx;
      cnt_p0     <= cnt_nx;
      idx_p0     <= idx_nx;
      started_p0 <= 1'b1;
      sh_val     <= sh_val_nx;
      sh_en      <= sh_en_nx;
      sh_dp      <= sh_dp_nx;
      if (commit)    pend_flag <= 1'b0;
      else if (xfer) pend_flag <= 1'b1;
      an_p1      <= an_nx;
      seg_p1     <= seg_nx;
      dp_p1      <= dp_nx;
      frame_p1   <= boundary;
    end
  end

  // Pending payload is only meaningful while pend_flag is set.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pd_val <= upd_value;
      pd_en  <= upd_en;
      pd_dp  <= upd_dp;
    end
  end

  assign an    = an_p1;
  assign seg   = seg_p1;
  assign dp    = dp_p1;
  assign frame = frame_p1;

endmodule
